// File: rtl/mul32_seq_pkg.sv
// Shared constants for the sequential shift-add multiplier: operand width,
// last iteration index and controller state encoding.
package mul32_seq_pkg;
  localparam int         MUL_W         = 32;
  localparam logic [4:0] MUL_ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/mul32_seq_add32_core.sv
// 32-bit ripple-carry adder, same structure as the add/subtract datapath adder.
module add32_core
  import mul32_seq_pkg::*;
(
  input  logic [MUL_W-1:0] x,
  input  logic [MUL_W-1:0] y,
  input  logic             cin,
  output logic [MUL_W-1:0] sum,
  output logic             cout
);
  logic [MUL_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < MUL_W; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[MUL_W];
endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier reusing one 32-bit adder.
// Optional macro ZERO_SKIP_EN: zero operands bypass RUN and complete next cycle.
module mul32_seq
  import mul32_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  input  logic                 start,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*MUL_W-1:0]   product
);
  mul_state_e           state_q, state_d;
  logic [MUL_W-1:0]     m_q, m_d;
  logic [MUL_W-1:0]     q_q, q_d;
  logic [MUL_W-1:0]     acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2*MUL_W-1:0]   product_q, product_d;

  logic [MUL_W-1:0]     add_y, add_s;
  logic                 add_c;

  // Gating the adder input instead of its output: acc + 0 == {0, acc}.
  assign add_y = q_q[0] ? m_q : '0;

  add32_core u_add (
    .x    (acc_q),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MUL_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        ready = 1'b1;
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_RUN;
`ifdef ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            product_d = '0;
            state_d   = MUL_DONE;
          end
`endif
        end
      end
      MUL_RUN: begin
        busy  = 1'b1;
        // {acc,q} <= {c,s,q[31:1]}: the 65-bit partial shifts right one place.
        acc_d = {add_c, add_s[MUL_W-1:1]};
        q_d   = {add_s[0], q_q[MUL_W-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_ITER_LAST) begin
          product_d = {add_c, add_s, q_q[MUL_W-1:1]};
          state_d   = MUL_DONE;
        end
      end
      MUL_DONE: begin
        done    = 1'b1;
        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign product = product_q;
endmodule
